// File: rtl/sw_capture_4b.sv
// sw_capture_4b: debounced 4-bit switch capture feeding a 4-bit enable register.
//
// The switch vector is synchronized, and a change must hold steady for DEB_CYCLES
// consecutive cycles. The block then issues exactly one single-cycle write strobe
// that carries the settled value.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   rst_n    in   1  synchronous active-low reset
//   sw_in    in   4  raw asynchronous switch levels
//   wr_en    out  1  one-cycle write strobe (state == COMMIT)
//   wr_data  out  4  value to write; holds last committed value between strobes
//   stable   out  4  current debounced (last committed) value
//   busy     out  1  high while a change is settling or committing
module sw_capture_4b #(
  parameter int unsigned DEB_CYCLES = 1250000,
  parameter int unsigned CNT_W      = $clog2(DEB_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw_in,
  output logic       wr_en,
  output logic [3:0] wr_data,
  output logic [3:0] stable,
  output logic       busy
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StCommit = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEB_CYCLES - 1);

  logic [3:0]       sync1_q;
  logic [3:0]       s_q;
  state_e           state_q;
  logic [3:0]       cand_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       stable_q;
  logic [3:0]       wr_data_q;

  // Two-flop synchronizer; nothing else looks at sw_in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 4'b0;
      s_q     <= 4'b0;
    end else begin
      sync1_q <= sw_in;
      s_q     <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cand_q    <= 4'b0;
      cnt_q     <= '0;
      stable_q  <= 4'b0;
      wr_data_q <= 4'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (s_q != stable_q) begin
            cand_q  <= s_q;
            cnt_q   <= '0;
            state_q <= StSettle;
          end
        end
        StSettle: begin
          if (s_q == stable_q) begin
            // Input fell back to the committed value: drop the candidate silently.
            cnt_q   <= '0;
            state_q <= StIdle;
          end else if (s_q != cand_q) begin
            // Any bit change restarts the settle window on the new vector.
            cand_q <= s_q;
            cnt_q  <= '0;
          end else if (cnt_q == CntLast) begin
            wr_data_q <= cand_q;
            stable_q  <= cand_q;
            state_q   <= StCommit;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StCommit: begin
          // Input is ignored here; a pending difference is seen next IDLE cycle.
          cnt_q   <= '0;
          state_q <= StIdle;
        end
        default: begin
          cnt_q   <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign wr_en   = (state_q == StCommit);
  assign busy    = (state_q != StIdle);
  assign wr_data = wr_data_q;
  assign stable  = stable_q;

endmodule

// File: tb/tb_sw_capture_4b.sv
module tb_sw_capture_4b;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw_in;
  logic       wr_en;
  logic [3:0] wr_data;
  logic [3:0] stable;
  logic       busy;

  int n_tests;
  int n_fail;

  sw_capture_4b #(
    .DEB_CYCLES(4)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_in  (sw_in),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .stable (stable),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // One rising edge, then settle to the falling edge where outputs are sampled
  // and the next inputs are driven.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Clean change from old_v to new_v applied before E0: strobe between E6 and E7.
  task automatic clean_change(input string tag, input logic [3:0] old_v,
                              input logic [3:0] new_v);
    sw_in = new_v;
    for (int e = 0; e <= 8; e++) begin
      tick();
      check({tag, ".wr_en"}, 32'(wr_en), 32'(e == 6));
      check({tag, ".busy"}, 32'(busy), 32'(e >= 2 && e <= 6));
      check({tag, ".stable"}, 32'(stable), 32'((e >= 6) ? new_v : old_v));
      if (e >= 6) check({tag, ".wr_data"}, 32'(wr_data), 32'(new_v));
    end
  endtask

  initial begin
    int strobes;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    sw_in   = 4'b1010;
    @(negedge clk);

    // Reset held for 3 edges with a nonzero input.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst.wr_en", 32'(wr_en), 32'd0);
      check("rst.wr_data", 32'(wr_data), 32'd0);
      check("rst.stable", 32'(stable), 32'd0);
      check("rst.busy", 32'(busy), 32'd0);
    end
    sw_in = 4'b0000;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("idle.busy", 32'(busy), 32'd0);
    end

    clean_change("clean", 4'b0000, 4'b0101);

    // Glitch to 0111 for 3 cycles, then back to the committed value.
    sw_in = 4'b0111;
    for (int e = 0; e < 13; e++) begin
      if (e == 3) sw_in = 4'b0101;
      tick();
      if (e == 2) check("glitch.busy_hi", 32'(busy), 32'd1);
      check("glitch.wr_en", 32'(wr_en), 32'd0);
      check("glitch.stable", 32'(stable), 32'h5);
    end
    check("glitch.busy_lo", 32'(busy), 32'd0);

    clean_change("to0a", 4'b0101, 4'b0000);

    // Bounce: 1000 (2 cycles), 0100 (1 cycle), 1000 held; last change before E3.
    strobes = 0;
    for (int e = 0; e < 13; e++) begin
      if (e == 0) sw_in = 4'b1000;
      if (e == 2) sw_in = 4'b0100;
      if (e == 3) sw_in = 4'b1000;
      tick();
      if (wr_en) strobes++;
      check("bounce.wr_en", 32'(wr_en), 32'(e == 9));
      if (e == 9) check("bounce.wr_data", 32'(wr_data), 32'h8);
    end
    check("bounce.strobes", 32'(strobes), 32'd1);
    check("bounce.stable", 32'(stable), 32'h8);

    clean_change("to0b", 4'b1000, 4'b0000);

    // Reset in the middle of SETTLE with 1111 held.
    sw_in = 4'b1111;
    for (int e = 0; e < 3; e++) tick();
    check("midrst.settling", 32'(busy), 32'd1);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("midrst.wr_en", 32'(wr_en), 32'd0);
      check("midrst.busy", 32'(busy), 32'd0);
      check("midrst.stable", 32'(stable), 32'd0);
    end
    rst_n = 1'b1;
    strobes = 0;
    for (int e = 0; e <= 9; e++) begin
      tick();
      if (wr_en) strobes++;
      check("midrst.strobe", 32'(wr_en), 32'(e == 6));
      if (e == 6) check("midrst.wr_data", 32'(wr_data), 32'hf);
    end
    check("midrst.strobes", 32'(strobes), 32'd1);

    clean_change("to0c", 4'b1111, 4'b0000);

    // Staggered bits: bit0 before E0, bit1 before E2.
    strobes = 0;
    for (int e = 0; e < 12; e++) begin
      if (e == 0) sw_in = 4'b0001;
      if (e == 2) sw_in = 4'b0011;
      tick();
      if (wr_en) strobes++;
      check("stagger.wr_en", 32'(wr_en), 32'(e == 8));
      if (e == 8) check("stagger.wr_data", 32'(wr_data), 32'h3);
    end
    check("stagger.strobes", 32'(strobes), 32'd1);
    check("stagger.stable", 32'(stable), 32'h3);
    check("stagger.busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
